// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module   : program_loader
// Brief    : Byte-stream program loader. Assembles 16-bit instruction words
//            (high byte first), writes them into instruction memory, holds
//            the processor in reset while loading and flags unknown opcodes.
// Revision : 1.0 - initial release
// ============================================================================
module program_loader #(
  parameter int ADDR_W = 8,
  parameter int MAX_OP = 5
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Abort,
  input  logic [7:0]        Byte_in,
  input  logic              Byte_valid,
  output logic              Byte_ready,
  output logic [ADDR_W-1:0] I_Addr,
  output logic [15:0]       I_Data,
  output logic              I_Wr,
  output logic              CPU_Reset,
  output logic              Busy,
  output logic              Done,
  output logic              Bad_op,
  output logic [ADDR_W:0]   Words
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_HI    = 3'd2,
    S_LO    = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [3:0]        MAX_OP_4 = 4'(MAX_OP);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  state_t            state;
  state_t            state_next;
  logic              loaded;
  logic              loaded_next;
  logic [ADDR_W-1:0] len_n;
  logic [ADDR_W-1:0] index;
  logic [7:0]        hi_byte;
  logic              xfer;
  logic              last_word;
  logic              bad_opcode;
  logic              start_ok;

  assign xfer       = Byte_valid & Byte_ready;
  // N=0 wraps to all-ones here, which gives the full 2**ADDR_W word image.
  assign last_word  = (index == (len_n - ONE));
  assign bad_opcode = (I_Data[15:12] > MAX_OP_4);
  assign start_ok   = (state == S_IDLE) && Start && !Abort;

  // State and load-status registers; CPU_Reset follows the next-state view so
  // it rises in the very cycle after Start and falls right after DONE.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= S_IDLE;
      loaded    <= 1'b0;
      CPU_Reset <= 1'b1;
    end else begin
      state     <= state_next;
      loaded    <= loaded_next;
      CPU_Reset <= (state_next != S_IDLE) | ~loaded_next;
    end
  end

  // Next-state logic and per-state strobes; Abort overrides every busy state.
  always_comb begin
    state_next  = state;
    loaded_next = loaded;
    Byte_ready  = 1'b0;
    I_Wr        = 1'b0;
    Done        = 1'b0;
    Busy        = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (Start && !Abort) begin
          state_next  = S_LEN;
          loaded_next = 1'b0;
        end
      end
      S_LEN: begin
        Byte_ready = 1'b1;
        if (xfer) state_next = S_HI;
      end
      S_HI: begin
        Byte_ready = 1'b1;
        if (xfer) state_next = S_LO;
      end
      S_LO: begin
        Byte_ready = 1'b1;
        if (xfer) state_next = S_WRITE;
      end
      S_WRITE: begin
        I_Wr       = 1'b1;
        state_next = last_word ? S_DONE : S_HI;
      end
      S_DONE: begin
        Done        = 1'b1;
        state_next  = S_IDLE;
        loaded_next = 1'b1;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    if (Abort && (state != S_IDLE)) begin
      state_next  = S_IDLE;
      loaded_next = 1'b0;
    end
  end

  // Datapath: length, word index, byte assembly, write port and statistics.
  // The write port is loaded on the lo-byte transfer so it is valid during
  // WRITE and simply holds afterwards.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      len_n   <= '0;
      index   <= '0;
      hi_byte <= '0;
      I_Addr  <= '0;
      I_Data  <= '0;
      Bad_op  <= 1'b0;
      Words   <= '0;
    end else begin
      if (start_ok) begin
        Bad_op <= 1'b0;
        Words  <= '0;
      end
      if ((state == S_LEN) && xfer && !Abort) begin
        len_n <= ADDR_W'(Byte_in);
        index <= '0;
      end
      if ((state == S_HI) && xfer && !Abort) begin
        hi_byte <= Byte_in;
      end
      if ((state == S_LO) && xfer && !Abort) begin
        I_Data <= {hi_byte, Byte_in};
        I_Addr <= index;
      end
      if (state == S_WRITE) begin
        if (bad_opcode) Bad_op <= 1'b1;
        Words <= Words + 1'b1;
        if (!last_word) index <= index + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_loader
// Brief    : Self-checking bench for program_loader: table of single-word
//            loads plus directed multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [7:0]  i_addr;
  logic [15:0] i_data;
  logic        i_wr;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        bad_op;
  logic [8:0]  words;

  int total = 0;
  int bad   = 0;

  // Write/handshake monitor, sampled on the falling edge.
  logic [15:0] mem [0:255];
  int          wr_count   = 0;
  int          done_count = 0;
  int          xfer_count = 0;
  logic [7:0]  last_addr  = 8'h00;

  program_loader #(.ADDR_W(8), .MAX_OP(5)) dut (
    .Clock      (clk),
    .Reset      (rst),
    .Start      (start),
    .Abort      (abort),
    .Byte_in    (byte_in),
    .Byte_valid (byte_valid),
    .Byte_ready (byte_ready),
    .I_Addr     (i_addr),
    .I_Data     (i_data),
    .I_Wr       (i_wr),
    .CPU_Reset  (cpu_reset),
    .Busy       (busy),
    .Done       (done),
    .Bad_op     (bad_op),
    .Words      (words)
  );

  always #5 clk = ~clk;

  // Record every memory write, Done pulse and byte transfer.
  always @(negedge clk) begin
    if (i_wr) begin
      mem[i_addr] = i_data;
      wr_count    = wr_count + 1;
      last_addr   = i_addr;
    end
    if (done) done_count = done_count + 1;
    if (byte_valid && byte_ready) xfer_count = xfer_count + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present a byte and hold it until the loader takes it (bounded).
  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    @(negedge clk);
    while (!byte_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!byte_ready) check("byte_accept_timeout", {31'd0, byte_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] w);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic wait_idle();
    int w = 0;
    while (busy && w < 2000) begin
      tick();
      w++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  typedef struct packed {
    logic [15:0] word;
    logic        exp_bad;
  } vec_t;

  vec_t tbl [6];
  int   wr0, dn0, xf0;

  initial begin
    tbl[0] = '{word: 16'h7ABC, exp_bad: 1'b1};
    tbl[1] = '{word: 16'h5FFF, exp_bad: 1'b0};
    tbl[2] = '{word: 16'h6000, exp_bad: 1'b1};
    tbl[3] = '{word: 16'h0000, exp_bad: 1'b0};
    tbl[4] = '{word: 16'hFABC, exp_bad: 1'b1};
    tbl[5] = '{word: 16'h1234, exp_bad: 1'b0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset values
    check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_i_addr",     {24'd0, i_addr},     32'd0);
    check("rst_i_data",     {16'd0, i_data},     32'd0);
    check("rst_i_wr",       {31'd0, i_wr},       32'd0);
    check("rst_cpu_reset",  {31'd0, cpu_reset},  32'd1);
    check("rst_busy",       {31'd0, busy},       32'd0);
    check("rst_done",       {31'd0, done},       32'd0);
    check("rst_bad_op",     {31'd0, bad_op},     32'd0);
    check("rst_words",      {23'd0, words},      32'd0);

    // Two-word load, Byte_valid held high
    wr0 = wr_count; dn0 = done_count;
    start_pulse();
    check("s1_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h02);
    send_word(16'h21A0);
    send_word(16'h3012);
    check("s1_lat_wr",   {31'd0, i_wr},   32'd1);
    check("s1_lat_addr", {24'd0, i_addr}, 32'd1);
    check("s1_lat_data", {16'd0, i_data}, 32'h3012);
    byte_valid = 1'b0;
    tick();
    check("s1_done_pulse", {31'd0, done},      32'd1);
    check("s1_cpurst_dn",  {31'd0, cpu_reset}, 32'd1);
    tick();
    check("s1_done_low",   {31'd0, done},      32'd0);
    check("s1_busy_low",   {31'd0, busy},      32'd0);
    check("s1_cpurst_rel", {31'd0, cpu_reset}, 32'd0);
    check("s1_words",      {23'd0, words},     32'd2);
    check("s1_bad_op",     {31'd0, bad_op},    32'd0);
    check("s1_wr_cnt",     wr_count - wr0,     32'd2);
    check("s1_done_cnt",   done_count - dn0,   32'd1);
    check("s1_mem0",       {16'd0, mem[0]},    32'h21A0);
    check("s1_mem1",       {16'd0, mem[1]},    32'h3012);

    // Table of single-word loads (opcode boundary around MAX_OP)
    for (int k = 0; k < 6; k++) begin
      wr0 = wr_count; dn0 = done_count;
      start_pulse();
      check("tbl_bad_cleared", {31'd0, bad_op},    32'd0);
      check("tbl_words_clr",   {23'd0, words},     32'd0);
      check("tbl_cpurst_up",   {31'd0, cpu_reset}, 32'd1);
      send_byte(8'h01);
      send_word(tbl[k].word);
      byte_valid = 1'b0;
      wait_idle();
      tick();
      check("tbl_mem0",     {16'd0, mem[0]},         {16'd0, tbl[k].word});
      check("tbl_bad_op",   {31'd0, bad_op},         {31'd0, tbl[k].exp_bad});
      check("tbl_words",    {23'd0, words},          32'd1);
      check("tbl_wr_cnt",   wr_count - wr0,          32'd1);
      check("tbl_done_cnt", done_count - dn0,        32'd1);
      check("tbl_cpurst",   {31'd0, cpu_reset},      32'd0);
    end

    // Three-word load with Byte_valid toggling
    wr0 = wr_count; dn0 = done_count; xf0 = xfer_count;
    start_pulse();
    send_byte(8'h03); byte_valid = 1'b0; tick();
    send_byte(8'h11); byte_valid = 1'b0; tick();
    send_byte(8'h11); byte_valid = 1'b0; tick();
    send_byte(8'h22); byte_valid = 1'b0; tick();
    send_byte(8'h22); byte_valid = 1'b0; tick();
    send_byte(8'h33); byte_valid = 1'b0; tick();
    send_byte(8'h33); byte_valid = 1'b0;
    wait_idle();
    check("tog_xfers",  xfer_count - xf0, 32'd7);
    check("tog_wr_cnt", wr_count - wr0,   32'd3);
    check("tog_mem0",   {16'd0, mem[0]},  32'h1111);
    check("tog_mem1",   {16'd0, mem[1]},  32'h2222);
    check("tog_mem2",   {16'd0, mem[2]},  32'h3333);
    check("tog_words",  {23'd0, words},   32'd3);
    check("tog_done",   done_count - dn0, 32'd1);

    // Ignored Start while busy, then Abort in LO of word 1
    wr0 = wr_count; dn0 = done_count;
    start_pulse();
    send_byte(8'h03);
    send_word(16'h4444);
    byte_valid = 1'b0;
    tick();
    start_pulse();
    check("ab_start_ign_busy",  {31'd0, busy},  32'd1);
    check("ab_start_ign_words", {23'd0, words}, 32'd1);
    send_byte(8'h55);
    byte_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    check("ab_busy",     {31'd0, busy},      32'd0);
    check("ab_cpurst",   {31'd0, cpu_reset}, 32'd1);
    check("ab_done_cnt", done_count - dn0,   32'd0);
    check("ab_wr_cnt",   wr_count - wr0,     32'd1);
    check("ab_last",     {24'd0, last_addr}, 32'd0);
    check("ab_words",    {23'd0, words},     32'd1);

    // Abort together with Start in IDLE
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    check("abst_busy",   {31'd0, busy},      32'd0);
    check("abst_cpurst", {31'd0, cpu_reset}, 32'd1);

    // Abort coinciding with WRITE: the write still lands
    wr0 = wr_count; dn0 = done_count;
    start_pulse();
    send_byte(8'h02);
    send_word(16'h3ABC);
    byte_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    check("abw_wr_cnt", wr_count - wr0,     32'd1);
    check("abw_mem0",   {16'd0, mem[0]},    32'h3ABC);
    check("abw_busy",   {31'd0, busy},      32'd0);
    check("abw_done",   done_count - dn0,   32'd0);
    check("abw_words",  {23'd0, words},     32'd1);
    check("abw_cpurst", {31'd0, cpu_reset}, 32'd1);

    // N=0: full 256-word image
    wr0 = wr_count; dn0 = done_count;
    start_pulse();
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      send_word(16'h2000 + 16'(i));
    end
    byte_valid = 1'b0;
    wait_idle();
    tick();
    check("full_last_addr", {24'd0, last_addr}, 32'hFF);
    check("full_wr_cnt",    wr_count - wr0,     32'd256);
    check("full_words",     {23'd0, words},     32'd256);
    check("full_done",      done_count - dn0,   32'd1);
    check("full_mem0",      {16'd0, mem[0]},    32'h2000);
    check("full_mem255",    {16'd0, mem[255]},  32'h20FF);
    check("full_cpurst",    {31'd0, cpu_reset}, 32'd0);

    // Asynchronous reset while in HI of word 1
    wr0 = wr_count; dn0 = done_count;
    start_pulse();
    send_byte(8'h02);
    send_word(16'hABCD);
    byte_valid = 1'b0;
    tick();
    check("ar_pre_bad",  {31'd0, bad_op}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("ar_busy",       {31'd0, busy},       32'd0);
    check("ar_byte_ready", {31'd0, byte_ready}, 32'd0);
    check("ar_i_addr",     {24'd0, i_addr},     32'd0);
    check("ar_i_data",     {16'd0, i_data},     32'd0);
    check("ar_i_wr",       {31'd0, i_wr},       32'd0);
    check("ar_cpurst",     {31'd0, cpu_reset},  32'd1);
    check("ar_bad_op",     {31'd0, bad_op},     32'd0);
    check("ar_words",      {23'd0, words},      32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("ar_wr_cnt", wr_count - wr0, 32'd1);
    wr0 = wr_count;
    start_pulse();
    send_byte(8'h01);
    send_word(16'h2468);
    byte_valid = 1'b0;
    wait_idle();
    tick();
    check("ar2_wr_cnt", wr_count - wr0,     32'd1);
    check("ar2_last",   {24'd0, last_addr}, 32'd0);
    check("ar2_mem0",   {16'd0, mem[0]},    32'h2468);
    check("ar2_words",  {23'd0, words},     32'd1);
    check("ar2_done",   done_count - dn0,   32'd1);
    check("ar2_cpurst", {31'd0, cpu_reset}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the instruction path. Receives a byte stream of a program image, assembles 16-bit instruction words (high byte first) and writes them into instruction memory.
- Holds the processor in reset while loading and releases it when the load completes.
- Flags any word whose opcode field Inst[15:12] is not one the controller decodes.
- Sits between a host or UART byte source and the instruction RAM / processor reset input.

Parameters:
- ADDR_W, 8, instruction memory address width; max program length is 2**ADDR_W words.
- MAX_OP, 5, highest legal opcode value (NOOP=0 .. HALT=5).

Ports:
- Clock  in  1  system clock, rising-edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  one-cycle pulse to begin a load; honoured only in IDLE.
- Abort  in  1  returns to IDLE from any state.
- Byte_in  in  8  stream data.
- Byte_valid  in  1  Byte_in is valid.
- Byte_ready  out  1  loader accepts a byte this cycle.
- I_Addr  out  ADDR_W  instruction memory write address.
- I_Data  out  16  instruction word to write.
- I_Wr  out  1  instruction memory write enable, one-cycle pulse.
- CPU_Reset  out  1  drives the processor Reset input.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse when a load completes.
- Bad_op  out  1  sticky flag: at least one written word had opcode > MAX_OP.
- Words  out  ADDR_W+1  number of words written in the current or last load.

Behaviour:
- Reset values: state IDLE, Byte_ready=0, I_Addr=0, I_Data=0, I_Wr=0, CPU_Reset=1, Busy=0, Done=0, Bad_op=0, Words=0, internal Loaded=0.
- Reset takes effect immediately (asynchronously). A load in progress is discarded, and no write is issued after Reset asserts.
- Handshake: a byte transfers on a rising edge where Byte_valid & Byte_ready. Byte_ready is 1 only in LEN, HI and LO. Byte_in is ignored when no transfer occurs, and there is no timeout.
- CPU_Reset = Busy | ~Loaded, registered. A new Start re-asserts it in the cycle after Start.
- States and transitions:
  - IDLE: on Start (and not Abort) -> LEN. In the same edge: clear Bad_op, clear Words, clear Loaded.
  - LEN: on transfer, latch N = Byte_in -> HI. N=0 means 2**ADDR_W words. The word index is cleared to 0.
  - HI: on transfer, latch hi byte -> LO.
  - LO: on transfer, latch lo byte -> WRITE.
  - WRITE: one cycle with I_Wr=1, I_Addr=index, I_Data={hi,lo}.
    - If I_Data[15:12] > MAX_OP, set Bad_op. The word is still written.
    - Words increments.
    - If index == N-1, go to DONE; else index+1 and go to HI.
  - DONE: one cycle. Done=1, set Loaded -> IDLE. CPU_Reset falls in the cycle after DONE.
- Latency: I_Wr asserts on the cycle immediately after the lo-byte transfer. The minimum is 3 cycles per word with back-to-back valid.
- Abort:
  - In any non-IDLE state, the next state is IDLE with Loaded=0, so CPU_Reset stays 1.
  - No Done pulse.
  - If Abort coincides with WRITE, the write in that cycle still completes.
  - Abort and Start together in IDLE: Abort wins, and the loader stays in IDLE.
- Start is ignored while Busy.
- I_Addr, I_Data and Words hold their values outside WRITE. I_Wr is 0 outside WRITE.
- Index arithmetic: the index is ADDR_W bits and never wraps within a load. With N=0 the final address is 2**ADDR_W-1.

Test Plan:
- Reset, then Start, bytes 02,21,A0,30,12 with Byte_valid held high -> writes 0x21A0@0 and 0x3012@1. Done pulses once, Words=2, Bad_op=0, CPU_Reset goes 1->0 after DONE.
- Start, N=01, word 0x7ABC -> write 0x7ABC@0, Bad_op=1. Next Start clears Bad_op to 0.
- Byte_valid toggling 1/0 every cycle during a 3-word load -> each byte is accepted exactly once, and the image matches the sent words.
- Abort asserted while in LO of word 1 -> IDLE, no write @1, no Done, CPU_Reset=1. Start pulse while Busy has no effect.
- N=00 with 256 words -> last write at I_Addr=FF, Words=256, then Done.
- Reset asserted asynchronously mid-HI -> all outputs return to reset values immediately. The subsequent Start performs a fresh load from address 0.
